// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants and helpers for the VGA raster generator.
//  - coord_t        : 10-bit pixel/line coordinate (covers totals up to 1024)
//  - strobes_t      : bundle of the three video strobes (hsync, vsync, blankN)
//  - STROBES_RESET  : idle strobe values (syncs inactive high, blanking active)
//  - hTotal/syncStart/syncEnd : derive raster totals and sync windows from
//                     the visible/porch/sync widths
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Default 640x480@60Hz timing, pixel clock = 50 MHz / 2
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_SYNC_DELAY = 1;

  // Largest total a coord_t can count through
  localparam int MAX_TOTAL = 1024;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blankN;
  } strobes_t;

  localparam strobes_t STROBES_RESET = '{hsync: 1'b1, vsync: 1'b1, blankN: 1'b0};

  // Full period of one axis: visible + front porch + sync + back porch
  function automatic int hTotal(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  // First coordinate where the sync pulse is asserted
  function automatic int syncStart(input int visible, input int front);
    return visible + front;
  endfunction

  // First coordinate after the sync pulse ends
  function automatic int syncEnd(input int visible, input int front, input int sync);
    return visible + front + sync;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// ---------------------------------------------------------------------------
// pixel_tick_div
// Divides the system clock down to the pixel rate.
//  i_clk      : system clock
//  i_botonRST : synchronous active-high reset
//  o_tick     : high for one clk cycle at the end of every pixel period
//  o_clkVGA   : registered 50%-duty pixel clock, rising edge mid-pixel
// ---------------------------------------------------------------------------
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_botonRST,
  output logic o_tick,
  output logic o_clkVGA
);

  localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  // A pixel period must split into two equal halves for the DAC clock
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : gBadDiv
    $error("pixel_tick_div: CLK_DIV must be even and >= 2");
  end

  logic [DW-1:0] r_divCnt;
  logic [DW-1:0] w_divNext;
  logic          r_clkVGA;

  // The tick marks the last clk of a pixel, so coordinates advance on the
  // edge that also wraps the divider back to zero
  assign o_tick    = (r_divCnt == DIV_LAST);
  assign w_divNext = o_tick ? '0 : r_divCnt + DW'(1);

  // Divider counter and pixel clock; the clock is derived from the next
  // count so it lines up with the divider value visible in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_botonRST) begin
      r_divCnt <= '0;
      r_clkVGA <= 1'b0;
    end else begin
      r_divCnt <= w_divNext;
      r_clkVGA <= (w_divNext >= DIV_HALF);
    end
  end

  assign o_clkVGA = r_clkVGA;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing from the board clock for the tic-tac-toe display.
//  clk        : system clock
//  botonRST   : synchronous active-high reset
//  cuentaX    : current column (undelayed)
//  cuentaY    : current line (undelayed)
//  hsync      : active-low horizontal sync, delayed SYNC_DELAY pixels
//  vsync      : active-low vertical sync, delayed SYNC_DELAY pixels
//  blank_n    : high in the visible region, delayed SYNC_DELAY pixels
//  sync_n     : DAC composite sync, tied low
//  clkVGA     : registered pixel clock for the DAC
//  frameStart : one-clk pulse when the raster wraps to (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic       clk,
  input  logic       botonRST,
  output logic [9:0] cuentaX,
  output logic [9:0] cuentaY,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       clkVGA,
  output logic       frameStart
);

  localparam int H_TOTAL = hTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = hTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t HS_START   = coord_t'(syncStart(H_VISIBLE, H_FRONT));
  localparam coord_t HS_END     = coord_t'(syncEnd(H_VISIBLE, H_FRONT, H_SYNC));
  localparam coord_t VS_START   = coord_t'(syncStart(V_VISIBLE, V_FRONT));
  localparam coord_t VS_END     = coord_t'(syncEnd(V_VISIBLE, V_FRONT, V_SYNC));
  localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);

  // The coordinate registers are 10 bits wide
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : gBadTotal
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  if (SYNC_DELAY < 0) begin : gBadDelay
    $error("vga_timing_gen: SYNC_DELAY must be >= 0");
  end

  logic     w_tick;
  coord_t   r_cuentaX;
  coord_t   r_cuentaY;
  logic     r_frameStart;
  logic     w_lineEnd;
  logic     w_frameEnd;
  strobes_t w_rawStrobes;
  strobes_t w_outStrobes;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) uTickDiv (
    .i_clk      (clk),
    .i_botonRST (botonRST),
    .o_tick     (w_tick),
    .o_clkVGA   (clkVGA)
  );

  assign w_lineEnd  = (r_cuentaX == H_LAST);
  assign w_frameEnd = w_lineEnd && (r_cuentaY == V_LAST);

  // Raster counters: column advances every pixel, line advances when the
  // column wraps; frameStart is raised on the same edge the raster lands
  // on (0,0) so it is high during the first clk of the new frame
  always_ff @(posedge clk) begin
    if (botonRST) begin
      r_cuentaX    <= '0;
      r_cuentaY    <= '0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_tick && w_frameEnd;
      if (w_tick) begin
        if (w_lineEnd) begin
          r_cuentaX <= '0;
          r_cuentaY <= w_frameEnd ? '0 : r_cuentaY + coord_t'(1);
        end else begin
          r_cuentaX <= r_cuentaX + coord_t'(1);
        end
      end
    end
  end

  // Undelayed strobes decoded from the current coordinates
  assign w_rawStrobes.hsync  = !((r_cuentaX >= HS_START) && (r_cuentaX < HS_END));
  assign w_rawStrobes.vsync  = !((r_cuentaY >= VS_START) && (r_cuentaY < VS_END));
  assign w_rawStrobes.blankN = (r_cuentaX < H_VIS_C) && (r_cuentaY < V_VIS_C);

  if (SYNC_DELAY == 0) begin : gNoDelay
    assign w_outStrobes = w_rawStrobes;
  end else begin : gDelay
    strobes_t r_line [SYNC_DELAY];

    // Pixel-rate shift line so the strobes stay aligned with the
    // consumer's registered rgb; it starts out filled with idle values
    always_ff @(posedge clk) begin
      if (botonRST) begin
        for (int i = 0; i < SYNC_DELAY; i++) begin
          r_line[i] <= STROBES_RESET;
        end
      end else if (w_tick) begin
        r_line[0] <= w_rawStrobes;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          r_line[i] <= r_line[i-1];
        end
      end
    end

    assign w_outStrobes = r_line[SYNC_DELAY-1];
  end

  assign cuentaX    = r_cuentaX;
  assign cuentaY    = r_cuentaY;
  assign hsync      = w_outStrobes.hsync;
  assign vsync      = w_outStrobes.vsync;
  assign blank_n    = w_outStrobes.blankN;
  assign sync_n     = 1'b0;
  assign frameStart = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Drives two copies of the timing generator from one clock and reset: the
// default 640x480 timing and a shrunken raster that completes many frames
// quickly. Expected outputs are computed from the number of clk edges since
// the last reset edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int cx;
    int cy;
    int hs;
    int vs;
    int bn;
    int cv;
    int fs;
  } expect_t;

  typedef struct {
    int div;
    int hv, hf, hsw, hb;
    int vv, vf, vsw, vb;
    int dly;
  } timing_t;

  localparam timing_t T_DEF   = '{div: 2, hv: 640, hf: 16, hsw: 96, hb: 48,
                                  vv: 480, vf: 10, vsw: 2, vb: 33, dly: 1};
  localparam timing_t T_SMALL = '{div: 4, hv: 16, hf: 2, hsw: 3, hb: 4,
                                  vv: 8, vf: 2, vsw: 2, vb: 3, dly: 2};

  logic       clk;
  logic       botonRST;

  logic [9:0] dCx, dCy, sCx, sCy;
  logic       dHs, dVs, dBn, dSn, dCv, dFs;
  logic       sHs, sVs, sBn, sSn, sCv, sFs;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  vga_timing_gen uDef (
    .clk        (clk),
    .botonRST   (botonRST),
    .cuentaX    (dCx),
    .cuentaY    (dCy),
    .hsync      (dHs),
    .vsync      (dVs),
    .blank_n    (dBn),
    .sync_n     (dSn),
    .clkVGA     (dCv),
    .frameStart (dFs)
  );

  vga_timing_gen #(
    .CLK_DIV    (4),
    .H_VISIBLE  (16),
    .H_FRONT    (2),
    .H_SYNC     (3),
    .H_BACK     (4),
    .V_VISIBLE  (8),
    .V_FRONT    (2),
    .V_SYNC     (2),
    .V_BACK     (3),
    .SYNC_DELAY (2)
  ) uSmall (
    .clk        (clk),
    .botonRST   (botonRST),
    .cuentaX    (sCx),
    .cuentaY    (sCy),
    .hsync      (sHs),
    .vsync      (sVs),
    .blank_n    (sBn),
    .sync_n     (sSn),
    .clkVGA     (sCv),
    .frameStart (sFs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: after k clk edges out of reset the raster has advanced k/div
  // pixels; strobes show the decode of the pixel dly positions earlier, or
  // idle values if the raster has not advanced that far yet
  function automatic expect_t model(input timing_t t, input int k);
    expect_t e;
    int hTot, vTot, frame, pix, cur, old, ox, oy;
    hTot  = t.hv + t.hf + t.hsw + t.hb;
    vTot  = t.vv + t.vf + t.vsw + t.vb;
    frame = hTot * vTot;
    pix   = k / t.div;
    cur   = pix % frame;
    e.cx  = cur % hTot;
    e.cy  = cur / hTot;
    e.cv  = ((k % t.div) >= (t.div / 2)) ? 1 : 0;
    e.fs  = ((k % t.div) == 0 && pix > 0 && cur == 0) ? 1 : 0;
    if (pix < t.dly) begin
      e.hs = 1;
      e.vs = 1;
      e.bn = 0;
    end else begin
      old  = (pix - t.dly) % frame;
      ox   = old % hTot;
      oy   = old / hTot;
      e.hs = (ox >= t.hv + t.hf && ox < t.hv + t.hf + t.hsw) ? 0 : 1;
      e.vs = (oy >= t.vv + t.vf && oy < t.vv + t.vf + t.vsw) ? 0 : 1;
      e.bn = (ox < t.hv && oy < t.vv) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s (edge %0d): observed %0d, expected %0d", tag, edgeCount, observed, expected);
    end
  endtask

  task automatic checkInstance(input string name, input timing_t t,
                               input logic [9:0] cx, input logic [9:0] cy,
                               input logic hs, input logic vs, input logic bn,
                               input logic sn, input logic cv, input logic fs);
    expect_t e;
    e = model(t, edgeCount);
    checkOutput({name, ".cuentaX"},    32'(cx), 32'(e.cx));
    checkOutput({name, ".cuentaY"},    32'(cy), 32'(e.cy));
    checkOutput({name, ".hsync"},      32'(hs), 32'(e.hs));
    checkOutput({name, ".vsync"},      32'(vs), 32'(e.vs));
    checkOutput({name, ".blank_n"},    32'(bn), 32'(e.bn));
    checkOutput({name, ".sync_n"},     32'(sn), 32'd0);
    checkOutput({name, ".clkVGA"},     32'(cv), 32'(e.cv));
    checkOutput({name, ".frameStart"}, 32'(fs), 32'(e.fs));
  endtask

  // One clk cycle: drive reset, count the edge, sample on the falling edge
  task automatic applyStimulus(input logic rst);
    botonRST = rst;
    @(posedge clk);
    if (rst) edgeCount = 0;
    else     edgeCount++;
    @(negedge clk);
    checkInstance("def",   T_DEF,   dCx, dCy, dHs, dVs, dBn, dSn, dCv, dFs);
    checkInstance("small", T_SMALL, sCx, sCy, sHs, sVs, sBn, sSn, sCv, sFs);
  endtask

  initial begin
    int runLen;
    int rstLen;
    botonRST = 1'b1;

    // Held reset, then a long free run: two full default lines, several
    // small frames including wrap and frameStart
    repeat (3) applyStimulus(1'b1);
    repeat (3500) applyStimulus(1'b0);

    // Resets of random length dropped at random points in the raster
    for (int seg = 0; seg < 12; seg++) begin
      runLen = int'($urandom_range(1, 1800));
      rstLen = int'($urandom_range(1, 3));
      repeat (rstLen) applyStimulus(1'b1);
      repeat (runLen) applyStimulus(1'b0);
    end

    // Final single-cycle reset and clean run
    applyStimulus(1'b1);
    repeat (3500) applyStimulus(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
